// File: rtl/mac_seq_ctrl.sv
// Sequencer for the serial shift-add multiplier-accumulator: load, WIDTH add/shift steps, accumulate, done.
// Define MAC_EARLY_EXIT_EN to skip adder cycles once the remaining multiplier bits are all zero.
module mac_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH),
  parameter int OPS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_acc,
  input  logic             mplr_lsb,
  input  logic             mplr_zero,
  output logic             ready,
  output logic             busy,
  output logic             ld_ops,
  output logic             init_p,
  output logic             add_en,
  output logic             shift_en,
  output logic             init_acc,
  output logic             acc_ld,
  output logic             done,
  output logic [OPS_W-1:0] ops_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
`ifdef MAC_EARLY_EXIT_EN
    ,
    S_FIXUP = 3'd5
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPS_W-1:0]   ops_q, ops_d;

`ifndef MAC_EARLY_EXIT_EN
  logic unused_mplr_zero;
  assign unused_mplr_zero = mplr_zero;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = ~ready;
  assign ops_cnt = ops_q;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    ld_ops   = 1'b0;
    init_p   = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    init_acc = 1'b0;
    acc_ld   = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A clear and a start in the same cycle are both honoured.
        init_acc = clr_acc;
        if (clr_acc) ops_d = '0;
        if (start)   state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ops  = 1'b1;
        init_p  = 1'b1;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        shift_en = 1'b1;
        add_en   = mplr_lsb;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_ACCUM;
`ifdef MAC_EARLY_EXIT_EN
        else if (mplr_zero)    state_d = S_FIXUP;
`endif
      end
`ifdef MAC_EARLY_EXIT_EN
      S_FIXUP: begin
        // Shift-only cycles keep the product aligned exactly as a full CALC run would.
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_ACCUM;
      end
`endif
      S_ACCUM: begin
        acc_ld  = 1'b1;
        ops_d   = ops_q + OPS_W'(1);
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
